cp0_exception_unit: RTL and testbench

//  Coprocessor-0 block for the single-cycle MIPS core: holds Status/Cause/EPC(/Count/Compare),

---
 rtl/cp0_pkg.sv | 24 ++
 rtl/cp0_timer.sv | 30 +++
 rtl/cp0_exception_unit.sv | 122 ++++++++++++
 tb/tb_cp0_exception_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, exception codes and Status/Cause bit positions
package cp0_pkg;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0800;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_PRID    = 5'd15;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 10;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 10;

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - free-running Count, Compare and the timer interrupt flag
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    // A zero Compare disables the match so the post-reset state never interrupts.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 32'd0;
            compare <= 32'd0;
            ti      <= 1'b0;
        end else begin
            count <= count_we ? wdata : count + 32'd1;
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (compare != 32'd0 && count == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exception_unit.sv
// rtl/cp0_exception_unit.sv - CP0 Status/Cause/EPC, interrupt and exception detection; CP0_TIMER_EN adds Count/Compare
module cp0_exception_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter logic [31:0] PRID       = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        IsCOP0,
    input  logic        IsEret,
    input  logic        mtc0,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        exc_sys,
    input  logic        exc_ri,
    input  logic        exc_ov,
    input  logic [5:0]  hw_int,
    output logic        HasExp,
    output logic [31:0] epc
);

    // The PC stage jumps to this address directly, so it must be word aligned.
    if (EXC_VECTOR[1:0] != 2'b00) begin : g_bad_vector
        $error("EXC_VECTOR must be word aligned");
    end

    logic        ie;
    logic        exl;
    logic [5:0]  im;
    logic [5:0]  ip_q;
    logic [4:0]  exc_code;
    logic [5:0]  ip;
    logic        timer_int;
    logic        int_take;
    logic        sync_exc;
    logic        cp0_write;
    logic        eret_take;
    logic [4:0]  exc_code_next;
    logic [31:0] status_word;
    logic [31:0] cause_word;

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (cp0_write && cp0_addr == CP0_REG_COUNT),
        .compare_we (cp0_write && cp0_addr == CP0_REG_COMPARE),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .ti         (timer_int)
    );
`else
    assign timer_int = 1'b0;
`endif

    assign ip        = {ip_q[5] | timer_int, ip_q[4:0]};
    assign int_take  = ie & ~exl & (|(ip & im));
    assign sync_exc  = exc_ri | exc_sys | exc_ov;
    assign HasExp    = int_take | sync_exc;
    assign cp0_write = IsCOP0 & mtc0 & ~HasExp;
    assign eret_take = IsCOP0 & IsEret & ~HasExp;

    always_comb begin
        exc_code_next = EXC_OV;
        if (int_take)     exc_code_next = EXC_INT;
        else if (exc_ri)  exc_code_next = EXC_RI;
        else if (exc_sys) exc_code_next = EXC_SYS;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ie       <= 1'b0;
            exl      <= 1'b0;
            im       <= 6'd0;
            ip_q     <= 6'd0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip_q <= hw_int;
            if (HasExp) begin
                exl      <= 1'b1;
                exc_code <= exc_code_next;
                // A nested exception must not lose the outer handler's return address.
                if (!exl) epc <= pc;
            end else begin
                if (eret_take) exl <= 1'b0;
                if (cp0_write && cp0_addr == CP0_REG_STATUS) begin
                    ie  <= wdata[STATUS_IE];
                    exl <= wdata[STATUS_EXL];
                    im  <= wdata[STATUS_IM_LSB +: 6];
                end
                if (cp0_write && cp0_addr == CP0_REG_EPC) epc <= wdata;
            end
        end
    end

    assign status_word = {16'd0, im, 8'd0, exl, ie};
    assign cause_word  = {16'd0, ip, 3'd0, exc_code, 2'd0};

    always_comb begin
        rdata = 32'd0;
        case (cp0_addr)
            CP0_REG_STATUS:  rdata = status_word;
            CP0_REG_CAUSE:   rdata = cause_word;
            CP0_REG_EPC:     rdata = epc;
            CP0_REG_PRID:    rdata = PRID;
`ifdef CP0_TIMER_EN
            CP0_REG_COUNT:   rdata = count;
            CP0_REG_COMPARE: rdata = compare;
`endif
            default:         rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb/tb_cp0_exception_unit.sv - directed self-checking bench for cp0_exception_unit
module tb_cp0_exception_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        IsCOP0;
    logic        IsEret;
    logic        mtc0;
    logic [4:0]  cp0_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc_sys;
    logic        exc_ri;
    logic        exc_ov;
    logic [5:0]  hw_int;
    logic        HasExp;
    logic [31:0] epc;

    int checks   = 0;
    int failures = 0;

    cp0_exception_unit #(
        .EXC_VECTOR (32'h0000_0800),
        .PRID       (32'h0000_0001)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .IsCOP0   (IsCOP0),
        .IsEret   (IsEret),
        .mtc0     (mtc0),
        .cp0_addr (cp0_addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .exc_sys  (exc_sys),
        .exc_ri   (exc_ri),
        .exc_ov   (exc_ov),
        .hw_int   (hw_int),
        .HasExp   (HasExp),
        .epc      (epc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] addr, input logic [31:0] expected);
        cp0_addr = addr;
        #1;
        check(tag, rdata, expected);
    endtask

    task automatic mtc0_write(input logic [4:0] addr, input logic [31:0] data);
        IsCOP0   = 1'b1;
        mtc0     = 1'b1;
        cp0_addr = addr;
        wdata    = data;
        step();
        IsCOP0 = 1'b0;
        mtc0   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc = 32'd0; IsCOP0 = 1'b0; IsEret = 1'b0; mtc0 = 1'b0;
        cp0_addr = 5'd0; wdata = 32'd0; exc_sys = 1'b0; exc_ri = 1'b0; exc_ov = 1'b0;
        hw_int = 6'd0;
        step(); step();
        rst = 1'b0;

        // reset state
        read_chk("rst_status", 5'd12, 32'h0);
        read_chk("rst_cause", 5'd13, 32'h0);
        read_chk("rst_epc", 5'd14, 32'h0);
        read_chk("rst_prid", 5'd15, 32'h1);
        check("rst_hasexp", {31'd0, HasExp}, 32'd0);
        read_chk("unmapped_9", 5'd9, 32'h0);

        // syscall
        pc = 32'h40; exc_sys = 1'b1; #1;
        check("sys_hasexp", {31'd0, HasExp}, 32'd1);
        step();
        exc_sys = 1'b0;
        check("sys_epc", epc, 32'h40);
        read_chk("sys_status", 5'd12, 32'h2);
        read_chk("sys_cause", 5'd13, 32'h20);

        // interrupt with 1-cycle latency
        mtc0_write(5'd12, 32'h0000_0401);
        read_chk("mtc0_status", 5'd12, 32'h401);
        hw_int = 6'b000001; pc = 32'h80; #1;
        check("int_not_yet", {31'd0, HasExp}, 32'd0);
        step();
        pc = 32'h84; #1;
        check("int_taken", {31'd0, HasExp}, 32'd1);
        step();
        check("int_epc", epc, 32'h84);
        read_chk("int_cause", 5'd13, 32'h400);
        read_chk("int_status", 5'd12, 32'h403);
        check("int_masked_by_exl", {31'd0, HasExp}, 32'd0);
        hw_int = 6'd0;
        step();

        // ERET back to EXL=0
        IsCOP0 = 1'b1; IsEret = 1'b1; #1;
        check("eret_epc", epc, 32'h84);
        step();
        IsCOP0 = 1'b0; IsEret = 1'b0;
        read_chk("eret_status", 5'd12, 32'h401);

        // RI + Ov + ERET + MTC0 together
        pc = 32'h200; exc_ri = 1'b1; exc_ov = 1'b1;
        IsCOP0 = 1'b1; IsEret = 1'b1; mtc0 = 1'b1; cp0_addr = 5'd14; wdata = 32'h100; #1;
        check("prio_hasexp", {31'd0, HasExp}, 32'd1);
        step();
        exc_ri = 1'b0; exc_ov = 1'b0; IsCOP0 = 1'b0; IsEret = 1'b0; mtc0 = 1'b0;
        read_chk("prio_cause", 5'd13, 32'h28);
        check("prio_epc", epc, 32'h200);
        read_chk("prio_status", 5'd12, 32'h403);

        // handler rewrites EPC then ERET
        mtc0_write(5'd14, 32'h44);
        IsCOP0 = 1'b1; IsEret = 1'b1; #1;
        check("eret_new_epc", epc, 32'h44);
        check("eret_no_exc", {31'd0, HasExp}, 32'd0);
        step();
        IsCOP0 = 1'b0; IsEret = 1'b0;
        read_chk("eret2_status", 5'd12, 32'h401);

        // nested overflow keeps EPC
        pc = 32'h300; exc_ov = 1'b1; step();
        pc = 32'h500; step();
        exc_ov = 1'b0;
        check("nested_epc", epc, 32'h300);
        read_chk("nested_cause", 5'd13, 32'h30);

        // Cause writes ignored, hw_int level pulse
        mtc0_write(5'd13, 32'hFFFF_FFFF);
        read_chk("cause_ro", 5'd13, 32'h30);
        hw_int = 6'b000001; step();
        read_chk("ip_level_set", 5'd13, 32'h430);
        hw_int = 6'd0; step();
        read_chk("ip_level_clr", 5'd13, 32'h30);

        // enabling IE with a pending interrupt
        hw_int = 6'b000001;
        mtc0_write(5'd12, 32'h0000_0400);
        #1;
        check("ie0_no_int", {31'd0, HasExp}, 32'd0);
        IsCOP0 = 1'b1; mtc0 = 1'b1; cp0_addr = 5'd12; wdata = 32'h401; #1;
        check("ie_write_cycle", {31'd0, HasExp}, 32'd0);
        step();
        IsCOP0 = 1'b0; mtc0 = 1'b0; #1;
        check("ie_int_next", {31'd0, HasExp}, 32'd1);
        hw_int = 6'd0;
        step();

`ifdef CP0_TIMER_EN
        begin
            bit found;
            rst = 1'b1; step(); rst = 1'b0;
            mtc0_write(5'd11, 32'd10);
            mtc0_write(5'd12, 32'h0000_8001);
            mtc0_write(5'd9, 32'd0);
            read_chk("timer_count0", 5'd9, 32'd0);
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                if (HasExp) found = 1'b1;
                else step();
            end
            check("timer_int_taken", {31'd0, found}, 32'd1);
            step();
            read_chk("timer_cause_ti", 5'd13, 32'h8000);
            mtc0_write(5'd11, 32'd1000);
            read_chk("timer_ti_clr", 5'd13, 32'h0);
            mtc0_write(5'd9, 32'hFFFF_FFFF);
            read_chk("timer_count_max", 5'd9, 32'hFFFF_FFFF);
            step();
            read_chk("timer_count_wrap", 5'd9, 32'h0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
